bicubic_result_packer: RTL and testbench
========================================

BICUBIC_RESULT_PACKER -- requirements
Module: bicubic_result_packer

Interface
REQ-001 SHALL have parameter LANES, default 4: output pixels per packed word.
REQ-002 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1: in_product/in_sign/in_last valid.
REQ-005 SHALL have port in_ready, output, 1: block accepts an input this cycle.
REQ-006 SHALL have port in_product, input, 8: inner-product magnitude from the upstream 4-tap multiply-accumulate stage.
REQ-007 SHALL have port in_sign, input, 1: inner-product sign (1 = negative).
REQ-008 SHALL have port in_last, input, 1: marks the last pixel of an output row.
REQ-009 SHALL have port out_valid, output, 1: out_data/out_keep/out_last valid.
REQ-010 SHALL have port out_ready, input, 1: downstream accepts the word.
REQ-011 SHALL have port out_data, output, 8*LANES: packed unsigned pixels; lane 0 in bits [7:0].
REQ-012 SHALL have port out_keep, output, LANES: per-lane valid mask.
REQ-013 SHALL have port out_last, output, 1: word closes a row.
REQ-014 SHALL have port clamp_cnt, output, 16: count of accepted inputs clamped to zero.

Function
REQ-015 An input SHALL transfer when in_valid && in_ready; an output SHALL transfer when out_valid && out_ready.
REQ-016 Clamp: in_sign=1 with nonzero in_product SHALL yield pixel 0; otherwise pixel = in_product; negative zero SHALL yield 0 and SHALL NOT count as clamped.
REQ-017 Each accepted pixel SHALL be written into lane fill_cnt of the packing register; fill_cnt SHALL increment, range 0..LANES-1.
REQ-018 A word SHALL complete when the byte written is lane LANES-1 or carries in_last; fill_cnt SHALL return to 0 on completion.
REQ-019 On completion with output slot free (!out_valid || out_ready) in the same cycle, the word SHALL load into the output register; out_valid SHALL assert the next cycle (latency 1 cycle from completing accept).
REQ-020 On completion with output slot busy, the word SHALL be held in the packing register with pending=1.
REQ-021 in_ready SHALL equal !pending (registered, no combinational path from in_valid).
REQ-022 When pending=1 and the output slot is free, the held word SHALL move to the output register and pending SHALL clear at that edge.
REQ-023 out_keep SHALL have bits [n-1:0] set for an n-lane word; unfilled lanes of out_data SHALL be 0.
REQ-024 out_last SHALL be 1 only for the word completed by an in_last byte.
REQ-025 out_data/out_keep/out_last SHALL remain stable while out_valid && !out_ready.
REQ-026 Steady state with out_ready=1 SHALL sustain in_ready=1 continuously (one input per cycle).
REQ-027 clamp_cnt SHALL saturate at 16'hFFFF.

Reset
REQ-028 rst_n low SHALL immediately clear fill_cnt, pending, packing register, output register, clamp_cnt; out_valid=0, out_keep=0, out_last=0, out_data=0, in_ready=1.
REQ-029 Reset mid-word or mid-stall SHALL discard partial and held words; no output after release until a new word completes.

Structure
REQ-030 Shared package bicubic_pkg SHALL hold PIX_W=8, default LANES=4, and CLAMP_CNT_W=16.
REQ-031 Sign-magnitude-to-unsigned clamp SHALL be sub-module bicubic_clamp (combinational: magnitude, sign -> pixel, clamped flag).

Verification
REQ-032 Inputs +10,+20,+30,+40 back-to-back, out_ready=1 -> one word 32'h281E140A, keep 4'hF, out_valid one cycle after 4th accept.
REQ-033 Inputs +5, -7, +9 (last) -> out_data 32'h00090005, keep 4'h7, out_last=1, clamp_cnt=1.
REQ-034 Eight inputs 1..8, out_ready=0 -> first word held in output, second pending, in_ready=0 after 8th accept; raise out_ready -> 32'h04030201 then 32'h08070605, in_ready=1 again.
REQ-035 Sign=1, magnitude 0 -> lane value 0, clamp_cnt unchanged.
REQ-036 Assert rst_n low after 2 accepted pixels and during a stall -> all outputs 0, in_ready=1 immediately; following 4 inputs produce exactly one fresh word.

Source files
------------

// File: rtl/bicubic_pkg.sv
// Shared constants for the bicubic result packing path.
// Pixel width, default lane count and clamp counter width.
package bicubic_pkg;

  localparam int PIX_W       = 8;
  localparam int DEF_LANES   = 4;
  localparam int CLAMP_CNT_W = 16;

endpackage

// File: rtl/bicubic_clamp.sv
// Sign-magnitude to unsigned pixel clamp (combinational).
// mag/sign in -> pixel out, clamped=1 when a nonzero negative was forced to 0.
module bicubic_clamp
  import bicubic_pkg::*;
(
  input  logic [PIX_W-1:0] mag,
  input  logic             sign,
  output logic [PIX_W-1:0] pixel,
  output logic             clamped
);

  // Negative zero passes through as 0 and is not a clamp event.
  assign clamped = sign & (|mag);
  assign pixel   = clamped ? '0 : mag;

endmodule

// File: rtl/bicubic_result_packer.sv
// Packs clamped pixels into LANES-wide words with keep/last framing.
// in_* valid/ready stream in, out_* valid/ready stream out, clamp_cnt stat.
module bicubic_result_packer
  import bicubic_pkg::*;
#(
  parameter int LANES = DEF_LANES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PIX_W-1:0]       in_product,
  input  logic                   in_sign,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PIX_W*LANES-1:0] out_data,
  output logic [LANES-1:0]       out_keep,
  output logic                   out_last,
  output logic [CLAMP_CNT_W-1:0] clamp_cnt
);

  localparam int FW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int DW = PIX_W * LANES;

  logic [FW-1:0]          fill_q, fill_d;
  logic [DW-1:0]          pack_q, pack_d;
  logic                   pend_q, pend_d;
  logic [LANES-1:0]       pkeep_q, pkeep_d;
  logic                   plast_q, plast_d;
  logic                   ovalid_q, ovalid_d;
  logic [DW-1:0]          odata_q, odata_d;
  logic [LANES-1:0]       okeep_q, okeep_d;
  logic                   olast_q, olast_d;
  logic [CLAMP_CNT_W-1:0] ccnt_q, ccnt_d;

  logic [PIX_W-1:0] pixel;
  logic             clamped;
  logic             accept;
  logic             slot_free;
  logic             complete;
  logic [DW-1:0]    wdata;
  logic [LANES-1:0] keep_now;

  bicubic_clamp u_clamp (
    .mag    (in_product),
    .sign   (in_sign),
    .pixel  (pixel),
    .clamped(clamped)
  );

  assign accept    = in_valid && !pend_q;
  assign slot_free = !ovalid_q || out_ready;
  assign complete  = accept &&
                     ((fill_q == FW'(LANES - 1)) || in_last);

  // Packing register with the incoming byte merged into lane fill_q,
  // and the keep mask for a word that would close at this lane.
  always_comb begin
    wdata    = pack_q;
    keep_now = '0;
    for (int i = 0; i < LANES; i++) begin
      if (FW'(i) == fill_q) begin
        wdata[i*PIX_W +: PIX_W] = pixel;
      end
      keep_now[i] = (FW'(i) <= fill_q);
    end
  end

  always_comb begin
    fill_d   = fill_q;
    pack_d   = pack_q;
    pend_d   = pend_q;
    pkeep_d  = pkeep_q;
    plast_d  = plast_q;
    ovalid_d = ovalid_q;
    odata_d  = odata_q;
    okeep_d  = okeep_q;
    olast_d  = olast_q;
    ccnt_d   = ccnt_q;

    if (ovalid_q && out_ready) begin
      ovalid_d = 1'b0;
    end

    // A held word drains first; accept is blocked while pending.
    if (pend_q && slot_free) begin
      ovalid_d = 1'b1;
      odata_d  = pack_q;
      okeep_d  = pkeep_q;
      olast_d  = plast_q;
      pend_d   = 1'b0;
      pack_d   = '0;
    end

    if (accept) begin
      if (complete) begin
        fill_d = '0;
        if (slot_free) begin
          ovalid_d = 1'b1;
          odata_d  = wdata;
          okeep_d  = keep_now;
          olast_d  = in_last;
          pack_d   = '0;
        end else begin
          pend_d  = 1'b1;
          pack_d  = wdata;
          pkeep_d = keep_now;
          plast_d = in_last;
        end
      end else begin
        fill_d = fill_q + 1'b1;
        pack_d = wdata;
      end
      if (clamped && (ccnt_q != '1)) begin
        ccnt_d = ccnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q   <= '0;
      pack_q   <= '0;
      pend_q   <= 1'b0;
      pkeep_q  <= '0;
      plast_q  <= 1'b0;
      ovalid_q <= 1'b0;
      odata_q  <= '0;
      okeep_q  <= '0;
      olast_q  <= 1'b0;
      ccnt_q   <= '0;
    end else begin
      fill_q   <= fill_d;
      pack_q   <= pack_d;
      pend_q   <= pend_d;
      pkeep_q  <= pkeep_d;
      plast_q  <= plast_d;
      ovalid_q <= ovalid_d;
      odata_q  <= odata_d;
      okeep_q  <= okeep_d;
      olast_q  <= olast_d;
      ccnt_q   <= ccnt_d;
    end
  end

  assign in_ready  = !pend_q;
  assign out_valid = ovalid_q;
  assign out_data  = odata_q;
  assign out_keep  = okeep_q;
  assign out_last  = olast_q;
  assign clamp_cnt = ccnt_q;

endmodule

// File: tb/tb_bicubic_result_packer.sv
// Self-checking bench for bicubic_result_packer (LANES=4).
// Directed sequences, a vector table and a random run against a queue model.
module tb_bicubic_result_packer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_product;
  logic        in_sign;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_last;
  logic [15:0] clamp_cnt;

  int n_chk;
  int n_fail;
  int n_words;

  bicubic_result_packer #(.LANES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_product(in_product),
    .in_sign   (in_sign),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_last  (out_last),
    .clamp_cnt (clamp_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: pixels accumulate into a list; a word is emitted
  // when the list holds 4 pixels or a pixel carries last.
  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } word_t;

  int    cur[$];
  word_t expq[$];
  int    mclamp;
  logic  stall;
  logic [36:0] sval;

  always @(negedge clk) begin
    if (!rst_n) begin
      cur.delete();
      expq.delete();
      mclamp = 0;
      stall  = 1'b0;
    end else begin
      if (stall) begin
        chk("hold_stable", {out_valid, out_data, out_keep}, sval[36:0]);
      end
      chk("clamp_cnt_model", clamp_cnt, mclamp);
      if (out_valid && out_ready) begin
        n_words++;
        if (expq.size() == 0) begin
          chk("spurious_word", out_valid, 0);
        end else begin
          word_t w;
          w = expq.pop_front();
          chk("word_data", out_data, w.data);
          chk("word_keep_last", {out_keep, out_last}, {w.keep, w.last});
        end
      end
      stall = out_valid && !out_ready;
      sval  = {out_valid, out_data, out_keep};
      if (in_valid && in_ready) begin
        int v;
        v = in_sign ? -int'(in_product) : int'(in_product);
        if (v < 0) begin
          if (mclamp < 65535) mclamp++;
          v = 0;
        end
        cur.push_back(v);
        if (cur.size() == 4 || in_last) begin
          word_t w;
          w.data = 0;
          for (int k = 0; k < cur.size(); k++) begin
            w.data = w.data + (cur[k] << (8 * k));
          end
          w.keep = 4'((1 << cur.size()) - 1);
          w.last = in_last;
          expq.push_back(w);
          cur.delete();
        end
      end
    end
  end

  task automatic send(input logic [7:0] m, input logic s,
                      input logic l);
    int t;
    in_valid   = 1'b1;
    in_product = m;
    in_sign    = s;
    in_last    = l;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("send_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sign  = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] mag;
    logic       sign;
    logic [7:0] exp_pix;
    logic       exp_clamp;
  } vec_t;

  vec_t tbl[8];
  int   base;
  int   w0;

  initial begin
    n_chk = 0;
    n_fail = 0;
    n_words = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_product = '0;
    in_sign = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b0;

    tbl[0] = '{8'h00, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{8'h00, 1'b1, 8'h00, 1'b0};
    tbl[2] = '{8'h07, 1'b1, 8'h00, 1'b1};
    tbl[3] = '{8'hFF, 1'b0, 8'hFF, 1'b0};
    tbl[4] = '{8'hFF, 1'b1, 8'h00, 1'b1};
    tbl[5] = '{8'h80, 1'b0, 8'h80, 1'b0};
    tbl[6] = '{8'h01, 1'b1, 8'h00, 1'b1};
    tbl[7] = '{8'h7F, 1'b0, 8'h7F, 1'b0};

    repeat (2) cyc();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_keep_last", {out_keep, out_last}, 0);
    chk("rst_clamp_cnt", clamp_cnt, 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    cyc();

    // Four positives back to back
    send(8'd10, 0, 0);
    chk("b2b_in_ready1", in_ready, 1);
    send(8'd20, 0, 0);
    send(8'd30, 0, 0);
    chk("b2b_no_early_valid", out_valid, 0);
    send(8'd40, 0, 0);
    chk("b2b_valid", out_valid, 1);
    chk("b2b_data", out_data, 32'h281E140A);
    chk("b2b_keep_last", {out_keep, out_last}, {4'hF, 1'b0});
    cyc();
    chk("b2b_consumed", out_valid, 0);

    // Short row with one clamp
    send(8'd5, 0, 0);
    send(8'd7, 1, 0);
    send(8'd9, 0, 1);
    chk("row_valid", out_valid, 1);
    chk("row_data", out_data, 32'h00090005);
    chk("row_keep_last", {out_keep, out_last}, {4'h7, 1'b1});
    chk("row_clamp_cnt", clamp_cnt, 1);
    cyc();

    // Backpressure: one word in output, one pending
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send(8'(i), 0, 0);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_word1", out_data, 32'h04030201);
    repeat (3) cyc();
    chk("bp_still_blocked", in_ready, 0);
    out_ready = 1'b1;
    cyc();
    chk("bp_word2", out_data, 32'h08070605);
    chk("bp_word2_valid", out_valid, 1);
    chk("bp_in_ready_back", in_ready, 1);
    cyc();
    chk("bp_drained", out_valid, 0);

    // Single-pixel rows from the table
    for (int i = 0; i < 8; i++) begin
      base = clamp_cnt;
      send(tbl[i].mag, tbl[i].sign, 1'b1);
      chk("tbl_valid", out_valid, 1);
      chk("tbl_data", out_data, {24'h0, tbl[i].exp_pix});
      chk("tbl_keep_last", {out_keep, out_last}, {4'h1, 1'b1});
      chk("tbl_clamp", clamp_cnt, base + tbl[i].exp_clamp);
      cyc();
    end

    // Reset mid-word during a stall
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) send(8'(i), 0, 0);
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_out_data", out_data, 0);
    chk("mrst_keep_last", {out_keep, out_last}, 0);
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_clamp", clamp_cnt, 0);
    cyc();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      cyc();
      chk("mrst_no_output", out_valid, 0);
    end
    w0 = n_words;
    send(8'h11, 0, 0);
    send(8'h22, 0, 0);
    send(8'h33, 0, 0);
    send(8'h44, 0, 0);
    chk("mrst_fresh", out_data, 32'h44332211);
    chk("mrst_fresh_keep", out_keep, 4'hF);
    repeat (3) cyc();
    chk("mrst_one_word", n_words - w0, 1);

    // Reset with a pending word
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send(8'(i), 0, 0);
    chk("prst_blocked", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("prst_in_ready", in_ready, 1);
    chk("prst_out_valid", out_valid, 0);
    cyc();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) begin
      cyc();
      chk("prst_no_output", out_valid, 0);
    end

    // Random traffic with one asynchronous reset in the middle
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk);
      #1;
      if (i == 700) begin
        rst_n = 1'b0;
        #1;
        chk("rnd_rst_in_ready", in_ready, 1);
        chk("rnd_rst_valid", out_valid, 0);
      end else begin
        rst_n = 1'b1;
      end
      in_valid   = ($urandom_range(0, 3) != 0);
      in_product = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      in_sign    = ($urandom_range(0, 2) == 0);
      in_last    = ($urandom_range(0, 5) == 0);
      out_ready  = ($urandom_range(0, 3) != 0);
    end
    cyc();
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) cyc();
    chk("rnd_drained", expq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
